// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle CPU control path and the ALU.
// The ALU and the control FSM both import this package, so they agree on one ALUOp encoding.
package alu_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] ALU_NOP   = OPW'(0);
  localparam logic [OPW-1:0] ALU_LUI   = OPW'(1);
  localparam logic [OPW-1:0] ALU_AUIPC = OPW'(2);
  localparam logic [OPW-1:0] ALU_ADD   = OPW'(3);
  localparam logic [OPW-1:0] ALU_SUB   = OPW'(4);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] ST_FETCH  = 3'd0;
  localparam logic [SW-1:0] ST_DECODE = 3'd1;
  localparam logic [SW-1:0] ST_EXEC   = 3'd2;
  localparam logic [SW-1:0] ST_MEM    = 3'd3;
  localparam logic [SW-1:0] ST_WB     = 3'd4;
  localparam logic [SW-1:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC4 = 2'd2;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JAL,
    CLS_BEQ,
    CLS_BNE,
    CLS_LOAD,
    CLS_STORE
  } ctrl_cls_e;

  typedef struct packed {
    ctrl_cls_e        cls;
    logic [OPW-1:0]   op;
    logic             a_sel;
    logic             b_sel;
    logic             illegal;
  } dec_t;

  // Regfile write source implied by an instruction class.
  function automatic logic [1:0] wsel_of(input ctrl_cls_e cls);
    case (cls)
      CLS_LOAD: wsel_of = WSEL_MEM;
      CLS_JAL:  wsel_of = WSEL_PC4;
      default:  wsel_of = WSEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I-subset decoder: instruction word to class, ALUOp and operand selects.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  always_comb begin
    dec         = '0;
    dec.cls     = CLS_ALU;
    dec.op      = ALU_NOP;
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          dec.op      = ALU_ADD;
          dec.illegal = 1'b0;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          dec.op      = ALU_SUB;
          dec.illegal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (funct3 == F3_ADD) begin
          dec.op      = ALU_ADD;
          dec.b_sel   = 1'b1;
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.op      = ALU_LUI;
        dec.b_sel   = 1'b1;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.op      = ALU_AUIPC;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.illegal = 1'b0;
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          dec.cls     = CLS_LOAD;
          dec.op      = ALU_ADD;
          dec.b_sel   = 1'b1;
          dec.illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_LW) begin
          dec.cls     = CLS_STORE;
          dec.op      = ALU_ADD;
          dec.b_sel   = 1'b1;
          dec.illegal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          dec.cls     = CLS_BEQ;
          dec.op      = ALU_SUB;
          dec.illegal = 1'b0;
        end else if (funct3 == F3_BNE) begin
          dec.cls     = CLS_BNE;
          dec.op      = ALU_SUB;
          dec.illegal = 1'b0;
        end
      end
      OPC_JAL: begin
        dec.cls     = CLS_JAL;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 32-bit ALU datapath.
// Strobes and pc_sel are combinational from state+inputs; all other outputs are registered.
module alu_ctrl_fsm #(
  parameter int unsigned OPW          = alu_pkg::OPW,
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    ir,
  input  logic           alu_zero,
  input  logic           imem_rvalid,
  input  logic           dmem_ack,
  output logic           imem_req,
  output logic           ir_we,
  output logic [OPW-1:0] alu_op,
  output logic           alu_a_sel,
  output logic           alu_b_sel,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic           rf_we,
  output logic [1:0]     rf_wsel,
  output logic           pc_we,
  output logic           pc_sel,
  output logic           retire,
  output logic           trap
);

  import alu_pkg::*;

  localparam int unsigned   CW          = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(MEM_WAIT_MAX - 1);
  localparam logic          HAS_TIMEOUT = (MEM_WAIT_MAX != 0);

  logic [SW-1:0] state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  ctrl_cls_e     cls_q;
  dec_t          dec;

  alu_ctrl_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // State and MEM wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, wait counter and PC/IR/regfile strobes.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    retire  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (imem_rvalid) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = dec.illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: begin
            cnt_d   = '0;
            state_d = ST_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            pc_we   = 1'b1;
            pc_sel  = (cls_q == CLS_BEQ) ? alu_zero : !alu_zero;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // An ack arriving on the limit cycle still completes the access.
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (HAS_TIMEOUT && cnt == CNT_LAST) begin
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (cls_q == CLS_JAL);
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    // Reset aborts the current instruction without emitting any pulse.
    if (rst) begin
      ir_we  = 1'b0;
      rf_we  = 1'b0;
      pc_we  = 1'b0;
      pc_sel = 1'b0;
      retire = 1'b0;
    end
  end

  // Registered requests, trap flag and the decode results held through EXEC/MEM/WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      trap      <= 1'b0;
      alu_op    <= '0;
      alu_a_sel <= 1'b0;
      alu_b_sel <= 1'b0;
      rf_wsel   <= WSEL_ALU;
      cls_q     <= CLS_ALU;
    end else begin
      imem_req <= (state_d == ST_FETCH);
      dmem_req <= (state_d == ST_MEM);
      dmem_we  <= (state_d == ST_MEM) && (cls_q == CLS_STORE);
      trap     <= (state_d == ST_TRAP);
      if (state == ST_DECODE) begin
        cls_q <= dec.cls;
        if (dec.illegal) begin
          alu_op    <= '0;
          alu_a_sel <= 1'b0;
          alu_b_sel <= 1'b0;
          rf_wsel   <= WSEL_ALU;
        end else begin
          alu_op    <= OPW'(dec.op);
          alu_a_sel <= dec.a_sel;
          alu_b_sel <= dec.b_sel;
          rf_wsel   <= wsel_of(dec.cls);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm with hand-computed expectations.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        alu_zero;
  logic        imem_rvalid;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_we;
  logic [4:0]  alu_op;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        pc_we;
  logic        pc_sel;
  logic        retire;
  logic        trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.OPW(5), .MEM_WAIT_MAX(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ir          (ir),
    .alu_zero    (alu_zero),
    .imem_rvalid (imem_rvalid),
    .dmem_ack    (dmem_ack),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .alu_op      (alu_op),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .retire      (retire),
    .trap        (trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Strobe vector order: {ir_we, rf_we, pc_we, retire}
  task automatic chk_strb(input string tag, input logic [3:0] want);
    chk(tag, {28'd0, ir_we, rf_we, pc_we, retire}, {28'd0, want});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Starts in a FETCH cycle; runs FETCH and DECODE of a legal instruction.
  task automatic fetch_decode(input string tag, input logic [31:0] ir_v);
    ir = ir_v;
    imem_rvalid = 1'b1;
    smp();
    chk({tag, "_f_ireq"}, {31'd0, imem_req}, 32'd1);
    chk_strb({tag, "_f_strb"}, 4'b1000);
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk_strb({tag, "_d_strb"}, 4'b0000);
    tick();
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ir_v, input logic [4:0] op,
                         input logic a, input logic b, input logic [1:0] wsel, input logic psel);
    fetch_decode(tag, ir_v);
    smp();
    chk({tag, "_e_op"}, {27'd0, alu_op}, {27'd0, op});
    chk({tag, "_e_sel"}, {30'd0, alu_a_sel, alu_b_sel}, {30'd0, a, b});
    chk_strb({tag, "_e_strb"}, 4'b0000);
    tick();
    smp();
    chk_strb({tag, "_wb_strb"}, 4'b0111);
    chk({tag, "_wb_wsel"}, {30'd0, rf_wsel}, {30'd0, wsel});
    chk({tag, "_wb_psel"}, {31'd0, pc_sel}, {31'd0, psel});
    chk({tag, "_wb_op"}, {27'd0, alu_op}, {27'd0, op});
    tick();
  endtask

  task automatic run_branch(input string tag, input logic [31:0] ir_v, input logic zero,
                            input logic psel);
    fetch_decode(tag, ir_v);
    alu_zero = zero;
    smp();
    chk({tag, "_e_op"}, {27'd0, alu_op}, 32'd4);
    chk_strb({tag, "_e_strb"}, 4'b0011);
    chk({tag, "_e_psel"}, {31'd0, pc_sel}, {31'd0, psel});
    tick();
    alu_zero = 1'b0;
    smp();
    chk({tag, "_next_ireq"}, {31'd0, imem_req}, 32'd1);
    chk_strb({tag, "_next_strb"}, 4'b0000);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ir = 32'h0;
    alu_zero = 1'b0;
    imem_rvalid = 1'b0;
    dmem_ack = 1'b0;
    tick();
    tick();
    smp();
    chk("rst_ireq", {31'd0, imem_req}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_op", {27'd0, alu_op}, 32'd0);
    chk("rst_dreq", {31'd0, dmem_req}, 32'd0);
    chk("rst_wsel", {30'd0, rf_wsel}, 32'd0);
    chk_strb("rst_strb", 4'b0000);
    rst = 1'b0;
    tick();
    smp();
    chk("idle_ireq", {31'd0, imem_req}, 32'd1);
    tick();

    run_alu("add", 32'h002081B3, 5'd3, 1'b0, 1'b0, 2'd0, 1'b0);
    run_alu("sub", 32'h402081B3, 5'd4, 1'b0, 1'b0, 2'd0, 1'b0);
    run_branch("beq_t", 32'h00000063, 1'b1, 1'b1);
    run_branch("bne_z", 32'h00001063, 1'b1, 1'b0);
    run_branch("beq_nt", 32'h00000063, 1'b0, 1'b0);
    run_branch("bne_t", 32'h00001063, 1'b0, 1'b1);
    run_alu("jal", 32'h0000006F, 5'd0, 1'b0, 1'b0, 2'd2, 1'b1);
    run_alu("auipc", 32'h00000097, 5'd2, 1'b1, 1'b1, 2'd0, 1'b0);
    run_alu("lui", 32'h000000B7, 5'd1, 1'b0, 1'b1, 2'd0, 1'b0);
    run_alu("addi", 32'h00100093, 5'd3, 1'b0, 1'b1, 2'd0, 1'b0);

    // lw with three wait cycles; imem_rvalid during EXEC must be ignored
    fetch_decode("lw", 32'h00002283);
    imem_rvalid = 1'b1;
    smp();
    chk_strb("lw_e_rvalid_ignored", 4'b0000);
    chk("lw_e_op", {27'd0, alu_op}, 32'd3);
    tick();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("lw_m_dreq", {31'd0, dmem_req}, 32'd1);
      chk("lw_m_dwe", {31'd0, dmem_we}, 32'd0);
      chk_strb("lw_m_strb", 4'b0000);
      tick();
    end
    dmem_ack = 1'b1;
    smp();
    chk("lw_ack_dreq", {31'd0, dmem_req}, 32'd1);
    chk_strb("lw_ack_strb", 4'b0000);
    tick();
    dmem_ack = 1'b0;
    smp();
    chk_strb("lw_wb_strb", 4'b0111);
    chk("lw_wb_wsel", {30'd0, rf_wsel}, 32'd1);
    chk("lw_wb_psel", {31'd0, pc_sel}, 32'd0);
    chk("lw_wb_dreq", {31'd0, dmem_req}, 32'd0);
    tick();

    // sw acked exactly on the limit cycle: completes, no trap
    fetch_decode("sw_lim", 32'h00502223);
    smp();
    chk_strb("sw_lim_e_strb", 4'b0000);
    tick();
    for (int k = 0; k < 15; k++) begin
      smp();
      chk("sw_lim_m_dwe", {31'd0, dmem_we}, 32'd1);
      chk_strb("sw_lim_m_strb", 4'b0000);
      tick();
    end
    dmem_ack = 1'b1;
    smp();
    chk_strb("sw_lim_ack_strb", 4'b0011);
    chk("sw_lim_ack_psel", {31'd0, pc_sel}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    smp();
    chk("sw_lim_trap", {31'd0, trap}, 32'd0);
    chk("sw_lim_ireq", {31'd0, imem_req}, 32'd1);
    tick();

    // sw never acked: traps after 16 MEM cycles
    fetch_decode("sw_to", 32'h00502223);
    smp();
    tick();
    for (int k = 0; k < 16; k++) begin
      smp();
      chk("sw_to_m_dreq", {31'd0, dmem_req}, 32'd1);
      chk("sw_to_m_dwe", {31'd0, dmem_we}, 32'd1);
      chk("sw_to_m_trap", {31'd0, trap}, 32'd0);
      chk_strb("sw_to_m_strb", 4'b0000);
      tick();
    end
    smp();
    chk("sw_to_trap", {31'd0, trap}, 32'd1);
    chk("sw_to_dreq", {31'd0, dmem_req}, 32'd0);
    chk("sw_to_op", {27'd0, alu_op}, 32'd3);
    tick();
    imem_rvalid = 1'b1;
    dmem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("trap_hold", {31'd0, trap}, 32'd1);
      chk("trap_hold_ireq", {31'd0, imem_req}, 32'd0);
      chk_strb("trap_hold_strb", 4'b0000);
      tick();
    end
    imem_rvalid = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    tick();
    smp();
    chk("sw_to_rst_trap", {31'd0, trap}, 32'd0);
    rst = 1'b0;
    tick();
    smp();
    chk("sw_to_rst_ireq", {31'd0, imem_req}, 32'd1);
    tick();

    // illegal opcode after a nonzero alu_op
    run_alu("addi2", 32'h00100093, 5'd3, 1'b0, 1'b1, 2'd0, 1'b0);
    fetch_decode("ill", 32'hFFFFFFFF);
    smp();
    chk("ill_trap", {31'd0, trap}, 32'd1);
    chk("ill_op", {27'd0, alu_op}, 32'd0);
    chk("ill_ireq", {31'd0, imem_req}, 32'd0);
    chk("ill_dreq", {31'd0, dmem_req}, 32'd0);
    chk_strb("ill_strb", 4'b0000);
    rst = 1'b1;
    tick();
    smp();
    chk("ill_rst_trap", {31'd0, trap}, 32'd0);
    chk("ill_rst_ireq", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    tick();
    smp();
    chk("ill_rst_ireq_next", {31'd0, imem_req}, 32'd1);
    tick();

    // reset in MEM of a lw, with ack present: no pulses, back in FETCH
    fetch_decode("lw_rst", 32'h00002283);
    smp();
    tick();
    rst = 1'b1;
    dmem_ack = 1'b1;
    smp();
    chk("lw_rst_m_dreq", {31'd0, dmem_req}, 32'd1);
    chk_strb("lw_rst_m_strb", 4'b0000);
    tick();
    rst = 1'b0;
    dmem_ack = 1'b0;
    smp();
    chk("lw_rst_dreq", {31'd0, dmem_req}, 32'd0);
    chk_strb("lw_rst_strb", 4'b0000);
    tick();
    imem_rvalid = 1'b1;
    smp();
    chk_strb("lw_rst_fetch", 4'b1000);
    tick();
    imem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
